// File: rtl/sparse_chunk_sram_rx_pkg.sv
// Shared types and constants for the sparse-chunk SRAM write-stream receiver.
// The beat record and index widths below describe the default stream geometry.
package sparse_chunk_sram_rx_pkg;

    localparam int DEF_BUS_SIZE       = 32;
    localparam int DEF_DAT_SIZE       = 8;
    localparam int DEF_WR_DAT_CYC_NUM = 4;
    localparam int DEF_CHUNK_NUM      = 16;

    localparam int DEF_BEAT_W  = $clog2(DEF_WR_DAT_CYC_NUM);
    localparam int DEF_CHUNK_W = $clog2(DEF_CHUNK_NUM);

    // Receiver FSM: IDLE waits for beat 0, FILL is mid-chunk.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    typedef enum logic [0:0] {
        RX_IDLE = ST_IDLE,
        RX_FILL = ST_FILL
    } rx_state_e;

    typedef struct packed {
        logic [DEF_BUS_SIZE-1:0]              map;
        logic [DEF_BUS_SIZE*DEF_DAT_SIZE-1:0] data;
    } beat_rec_t;

endpackage

// File: rtl/sparse_chunk_sram_rx_ram.sv
// Simple dual-port chunk buffer: one write, one registered read.
// A same-address read and write in one cycle returns the old contents.
module sparse_chunk_ram #(
    parameter int WIDTH = 288,
    parameter int DEPTH = 64,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sparse_chunk_sram_rx.sv
// Receiver for the sparse-chunk SRAM write stream: assembles beats into chunk
// slots, flags completed chunks with their nonzero count, and serves reads.
module sparse_chunk_sram_rx
    import sparse_chunk_sram_rx_pkg::*;
#(
    parameter int BUS_SIZE       = 32,
    parameter int DAT_SIZE       = 8,
    parameter int WR_DAT_CYC_NUM = 4,
    parameter int CHUNK_NUM      = 16,
    localparam int BW  = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1,
    localparam int CW  = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1,
    localparam int NZW = $clog2(BUS_SIZE*WR_DAT_CYC_NUM+1),
    localparam int DW  = BUS_SIZE*DAT_SIZE
) (
    input  logic                 rst_i,
    input  logic                 clk_i,
    input  logic                 wr_valid_i,
    input  logic [BUS_SIZE-1:0]  wr_sparsemap_i,
    input  logic [DW-1:0]        wr_nonzero_data_i,
    input  logic [BW-1:0]        wr_dat_count_i,
    input  logic [CW-1:0]        wr_chunk_count_i,
    input  logic                 rd_en_i,
    input  logic [CW-1:0]        rd_chunk_i,
    input  logic [BW-1:0]        rd_beat_i,
    output logic                 rd_valid_o,
    output logic [BUS_SIZE-1:0]  rd_sparsemap_o,
    output logic [DW-1:0]        rd_nonzero_data_o,
    input  logic                 clr_en_i,
    input  logic [CW-1:0]        clr_chunk_i,
    output logic [CHUNK_NUM-1:0] chunk_valid_o,
    output logic                 done_o,
    output logic [CW-1:0]        done_chunk_o,
    output logic [NZW-1:0]       done_nz_count_o,
    output logic                 err_seq_o,
    output logic                 err_ovw_o
);

    localparam int DEPTH = CHUNK_NUM*WR_DAT_CYC_NUM;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WR_DAT_CYC_NUM-1);

    typedef struct packed {
        logic [BUS_SIZE-1:0] map;
        logic [DW-1:0]       data;
    } beat_t;

    logic [0:0]     state;
    logic [BW-1:0]  exp_beat;
    logic [CW-1:0]  cur_chunk;
    logic [NZW-1:0] nz_acc;

    logic [NZW-1:0] beat_pop;
    logic [NZW-1:0] nz_base;
    logic [NZW-1:0] nz_total;
    logic           in_fill;
    logic           is_beat0;
    logic           slot_valid;
    logic           take_first;
    logic           take_next;
    logic           ovw;
    logic           bad_seq;
    logic           complete;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  rd_addr;
    logic [CHUNK_NUM-1:0] valid_next;
    beat_t          wr_beat;
    beat_t          rd_beat;

    always_comb begin
        beat_pop = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            beat_pop = beat_pop + NZW'(wr_sparsemap_i[i]);
        end
    end

    // A beat 0 always (re)starts a chunk unless its slot still holds a
    // completed chunk; any other beat must match the chunk in progress.
    always_comb begin
        in_fill    = (state == ST_FILL);
        is_beat0   = (wr_dat_count_i == '0);
        slot_valid = chunk_valid_o[wr_chunk_count_i];
        take_first = wr_valid_i && is_beat0 && !slot_valid;
        ovw        = wr_valid_i && is_beat0 && slot_valid;
        take_next  = wr_valid_i && in_fill && !is_beat0 &&
                     (wr_dat_count_i == exp_beat) &&
                     (wr_chunk_count_i == cur_chunk);
        bad_seq    = wr_valid_i && ((in_fill && is_beat0) ||
                                    (!is_beat0 && !take_next));
        complete   = (take_first && (WR_DAT_CYC_NUM == 1)) ||
                     (take_next && (exp_beat == LAST_BEAT));
        wr_en      = take_first || take_next;
        nz_base    = take_first ? '0 : nz_acc;
        nz_total   = nz_base + beat_pop;
    end

    always_comb begin
        valid_next = chunk_valid_o;
        if (clr_en_i) begin
            valid_next[clr_chunk_i] = 1'b0;
        end
        if (complete) begin
            valid_next[wr_chunk_count_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            exp_beat  <= '0;
            cur_chunk <= '0;
            nz_acc    <= '0;
        end else if (wr_valid_i) begin
            if (take_first && !complete) begin
                state     <= ST_FILL;
                exp_beat  <= BW'(1);
                cur_chunk <= wr_chunk_count_i;
                nz_acc    <= beat_pop;
            end else if (take_next && !complete) begin
                exp_beat <= exp_beat + BW'(1);
                nz_acc   <= nz_total;
            end else if (complete || is_beat0) begin
                state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chunk_valid_o   <= '0;
            done_o          <= 1'b0;
            done_chunk_o    <= '0;
            done_nz_count_o <= '0;
            err_seq_o       <= 1'b0;
            err_ovw_o       <= 1'b0;
            rd_valid_o      <= 1'b0;
        end else begin
            chunk_valid_o <= valid_next;
            done_o        <= complete;
            rd_valid_o    <= rd_en_i;
            if (complete) begin
                done_chunk_o    <= wr_chunk_count_i;
                done_nz_count_o <= nz_total;
            end
            if (bad_seq) begin
                err_seq_o <= 1'b1;
            end
            if (ovw) begin
                err_ovw_o <= 1'b1;
            end
        end
    end

    assign wr_addr = AW'(wr_chunk_count_i) * AW'(WR_DAT_CYC_NUM) + AW'(wr_dat_count_i);
    assign rd_addr = AW'(rd_chunk_i) * AW'(WR_DAT_CYC_NUM) + AW'(rd_beat_i);
    assign wr_beat = '{map: wr_sparsemap_i, data: wr_nonzero_data_i};

    sparse_chunk_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_beat),
        .rd_en   (rd_en_i),
        .rd_addr (rd_addr),
        .rd_data (rd_beat)
    );

    assign rd_sparsemap_o    = rd_beat.map;
    assign rd_nonzero_data_o = rd_beat.data;

endmodule

// File: tb/tb_sparse_chunk_sram_rx.sv
// Directed and randomized bench for sparse_chunk_sram_rx against a
// chunk-level reference model (partial chunk kept as a queue of beat maps).
module tb_sparse_chunk_sram_rx;

    localparam int BUS_SIZE  = 4;
    localparam int DAT_SIZE  = 8;
    localparam int WCN       = 2;
    localparam int CHUNK_NUM = 4;
    localparam int DW        = BUS_SIZE*DAT_SIZE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid;
    logic [3:0]    wr_map;
    logic [DW-1:0] wr_data;
    logic [0:0]    wr_beat;
    logic [1:0]    wr_chunk;
    logic          rd_en;
    logic [1:0]    rd_chunk;
    logic [0:0]    rd_beat;
    logic          rd_valid;
    logic [3:0]    rd_map;
    logic [DW-1:0] rd_data;
    logic          clr_en;
    logic [1:0]    clr_chunk;
    logic [3:0]    chunk_valid;
    logic          done;
    logic [1:0]    done_chunk;
    logic [3:0]    done_nz;
    logic          err_seq;
    logic          err_ovw;

    always #5 clk = ~clk;

    sparse_chunk_sram_rx #(
        .BUS_SIZE       (BUS_SIZE),
        .DAT_SIZE       (DAT_SIZE),
        .WR_DAT_CYC_NUM (WCN),
        .CHUNK_NUM      (CHUNK_NUM)
    ) dut (
        .rst_i             (rst),
        .clk_i             (clk),
        .wr_valid_i        (wr_valid),
        .wr_sparsemap_i    (wr_map),
        .wr_nonzero_data_i (wr_data),
        .wr_dat_count_i    (wr_beat),
        .wr_chunk_count_i  (wr_chunk),
        .rd_en_i           (rd_en),
        .rd_chunk_i        (rd_chunk),
        .rd_beat_i         (rd_beat),
        .rd_valid_o        (rd_valid),
        .rd_sparsemap_o    (rd_map),
        .rd_nonzero_data_o (rd_data),
        .clr_en_i          (clr_en),
        .clr_chunk_i       (clr_chunk),
        .chunk_valid_o     (chunk_valid),
        .done_o            (done),
        .done_chunk_o      (done_chunk),
        .done_nz_count_o   (done_nz),
        .err_seq_o         (err_seq),
        .err_ovw_o         (err_ovw)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [3:0]     m_map [CHUNK_NUM][WCN];
    logic [DW-1:0]  m_dat [CHUNK_NUM][WCN];
    bit             written [CHUNK_NUM][WCN];
    logic [3:0]     m_valid;
    bit             part_active;
    int             part_chunk;
    logic [3:0]     part_q[$];
    logic           m_err_seq, m_err_ovw, m_done, m_rd_valid;
    logic [1:0]     m_done_chunk;
    logic [3:0]     m_nz, m_rd_map;
    logic [DW-1:0]  m_rd_dat;

    logic [DW-1:0]  d0, d1, e0, e1, f0, f1, b0, c0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = '0; part_active = 0; part_q.delete();
        m_err_seq = 0; m_err_ovw = 0; m_done = 0; m_done_chunk = '0; m_nz = '0;
        m_rd_valid = 0; m_rd_map = '0; m_rd_dat = '0;
    endtask

    task automatic model_edge();
        bit complete;
        int ch, bt, sum;
        logic [3:0] clr_mask;
        complete = 0;
        ch = int'(wr_chunk);
        bt = int'(wr_beat);
        m_rd_valid = rd_en;
        if (rd_en) begin
            m_rd_map = m_map[rd_chunk][rd_beat];
            m_rd_dat = m_dat[rd_chunk][rd_beat];
        end
        clr_mask = '0;
        if (clr_en && m_valid[clr_chunk]) clr_mask[clr_chunk] = 1'b1;
        m_done = 0;
        if (wr_valid) begin
            if (bt == 0) begin
                if (part_active) begin
                    m_err_seq = 1; part_active = 0; part_q.delete();
                end
                if (m_valid[ch]) begin
                    m_err_ovw = 1;
                end else begin
                    m_map[ch][0] = wr_map; m_dat[ch][0] = wr_data; written[ch][0] = 1;
                    part_active = 1; part_chunk = ch; part_q.push_back(wr_map);
                end
            end else if (part_active && ch == part_chunk && bt == part_q.size()) begin
                m_map[ch][bt] = wr_map; m_dat[ch][bt] = wr_data; written[ch][bt] = 1;
                part_q.push_back(wr_map);
            end else begin
                m_err_seq = 1;
            end
            if (part_active && part_q.size() == WCN) begin
                sum = 0;
                foreach (part_q[k]) sum += $countones(part_q[k]);
                complete = 1; m_done = 1; m_done_chunk = 2'(ch); m_nz = 4'(sum);
                part_active = 0; part_q.delete();
            end
        end
        m_valid = m_valid & ~clr_mask;
        if (complete) m_valid[ch] = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(chunk_valid), 64'(m_valid));
        check({tag, ".done"}, 64'(done), 64'(m_done));
        check({tag, ".done_chunk"}, 64'(done_chunk), 64'(m_done_chunk));
        check({tag, ".done_nz"}, 64'(done_nz), 64'(m_nz));
        check({tag, ".err_seq"}, 64'(err_seq), 64'(m_err_seq));
        check({tag, ".err_ovw"}, 64'(err_ovw), 64'(m_err_ovw));
        check({tag, ".rd_valid"}, 64'(rd_valid), 64'(m_rd_valid));
        check({tag, ".rd_map"}, 64'(rd_map), 64'(m_rd_map));
        check({tag, ".rd_data"}, 64'(rd_data), 64'(m_rd_dat));
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_map = '0; wr_data = '0; wr_beat = '0; wr_chunk = '0;
        rd_en = 0; rd_chunk = '0; rd_beat = '0; clr_en = 0; clr_chunk = '0;
    endtask

    task automatic wr(input int ch, input int bt, input logic [3:0] m, input logic [DW-1:0] d);
        wr_valid = 1; wr_chunk = 2'(ch); wr_beat = 1'(bt); wr_map = m; wr_data = d;
    endtask

    task automatic rd(input int ch, input int bt);
        rd_en = 1; rd_chunk = 2'(ch); rd_beat = 1'(bt);
    endtask

    task automatic clr(input int ch);
        clr_en = 1; clr_chunk = 2'(ch);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        foreach (written[i, j]) written[i][j] = 0;
        #2;
        check_all("por");
        repeat (2) @(negedge clk);
        rst = 0;

        // Complete chunk 2, then read its second beat back
        d0 = $urandom; d1 = $urandom;
        wr(2, 0, 4'b1011, d0); tick("t1_b0");
        check("t1_no_done_yet", 64'(done), 64'(0));
        wr(2, 1, 4'b0001, d1); tick("t1_b1");
        check("t1_done", 64'(done), 64'(1));
        check("t1_done_chunk", 64'(done_chunk), 64'(2));
        check("t1_nz", 64'(done_nz), 64'(4));
        check("t1_valid", 64'(chunk_valid), 64'(4'b0100));
        rd(2, 1); tick("t1_rd");
        check("t1_done_pulse_end", 64'(done), 64'(0));
        check("t1_rd_valid", 64'(rd_valid), 64'(1));
        check("t1_rd_map", 64'(rd_map), 64'(4'b0001));
        check("t1_rd_data", 64'(rd_data), 64'(d1));

        // Beat 1 while idle is dropped
        wr(0, 1, 4'b1111, $urandom); tick("t2");
        check("t2_err_seq", 64'(err_seq), 64'(1));
        check("t2_valid", 64'(chunk_valid), 64'(4'b0100));

        // Chunk switch mid-fill restarts on the new chunk
        do_reset("t3_rst");
        wr(1, 0, 4'b0101, $urandom); tick("t3_c1b0");
        check("t3_err_clean", 64'(err_seq), 64'(0));
        wr(3, 0, 4'b1111, $urandom); tick("t3_c3b0");
        check("t3_err_seq", 64'(err_seq), 64'(1));
        wr(3, 1, 4'b0110, $urandom); tick("t3_c3b1");
        check("t3_done_chunk", 64'(done_chunk), 64'(3));
        check("t3_nz", 64'(done_nz), 64'(6));
        check("t3_valid", 64'(chunk_valid), 64'(4'b1000));

        // Overwrite protection and release
        e0 = $urandom; e1 = $urandom; f0 = $urandom; f1 = $urandom;
        wr(2, 0, 4'b0011, e0); tick("t4_b0");
        wr(2, 1, 4'b1000, e1); tick("t4_b1");
        check("t4_valid", 64'(chunk_valid), 64'(4'b1100));
        check("t4_ovw_clean", 64'(err_ovw), 64'(0));
        wr(2, 0, 4'b1111, ~e0); tick("t4_ovw");
        check("t4_err_ovw", 64'(err_ovw), 64'(1));
        rd(2, 0); tick("t4_rd_old");
        check("t4_kept_data", 64'(rd_data), 64'(e0));
        check("t4_kept_map", 64'(rd_map), 64'(4'b0011));
        clr(2); tick("t4_clr");
        check("t4_valid_clr", 64'(chunk_valid), 64'(4'b1000));
        wr(2, 0, 4'b0111, f0); tick("t4_rw0");
        wr(2, 1, 4'b1001, f1); tick("t4_rw1");
        check("t4_redone", 64'(done), 64'(1));
        check("t4_renz", 64'(done_nz), 64'(5));
        rd(2, 0); tick("t4_rd_new");
        check("t4_new_data", 64'(rd_data), 64'(f0));

        // Reset mid-chunk discards the partial chunk
        wr(0, 0, 4'b0001, $urandom); tick("t5_b0");
        rst = 1;
        model_reset();
        #1;
        check("t5_rst_valid", 64'(chunk_valid), 64'(0));
        check("t5_rst_err", 64'({err_seq, err_ovw}), 64'(0));
        check("t5_rst_rd", 64'({rd_valid, rd_map, rd_data}), 64'(0));
        check("t5_rst_done", 64'({done, done_chunk, done_nz}), 64'(0));
        @(negedge clk);
        rst = 0;
        wr(0, 1, 4'b0010, $urandom); tick("t5_b1");
        check("t5_err_seq", 64'(err_seq), 64'(1));
        check("t5_no_done", 64'(done), 64'(0));

        // Same-cycle read and write of one entry returns the old value
        b0 = $urandom; c0 = $urandom;
        wr(0, 0, 4'b1100, b0); tick("t6_w0");
        wr(0, 0, 4'b0011, c0); rd(0, 0); tick("t6_rw");
        check("t6_old", 64'(rd_data), 64'(b0));
        rd(0, 0); tick("t6_rd");
        check("t6_new", 64'(rd_data), 64'(c0));
        check("t6_new_map", 64'(rd_map), 64'(4'b0011));

        // Randomized traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            if (part_active && $urandom_range(0, 99) < 65) begin
                wr(part_chunk, part_q.size(), 4'($urandom), $urandom);
            end else if ($urandom_range(0, 99) < 75) begin
                wr($urandom_range(0, 3), $urandom_range(0, 1), 4'($urandom), $urandom);
            end
            if ($urandom_range(0, 99) < 20) clr($urandom_range(0, 3));
            begin
                int rc, rb;
                rc = $urandom_range(0, 3);
                rb = $urandom_range(0, 1);
                if ($urandom_range(0, 1) == 1 && written[rc][rb]) rd(rc, rb);
            end
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
